// File: rtl/step_bound_ctrl_pkg.sv
// Shared definitions for the step/bound controller: default widths,
// reset values of the bound registers, and the controller state type.
package step_bound_ctrl_pkg;

    localparam int W_DEF     = 31;
    localparam int X_RST_DEF = 500;
    localparam int Y_RST_DEF = 450;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : step_bound_ctrl_pkg

// File: rtl/step_bound_ctrl_step_counter.sv
// Index counter for step_bound_ctrl. Holds i, clears on request, and
// advances only while i < y, so i can never pass the target bound.
module step_counter
    import step_bound_ctrl_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,     // force i to 0 (has priority over inc)
    input  logic         inc,     // advance request, honoured only if i < y
    input  logic [W-1:0] y,       // target bound
    output logic [W-1:0] i,       // current index
    output logic         at_y,    // i == y
    output logic         lt_y,    // i < y, an inc this cycle will be taken
    output logic         hit_y    // an accepted inc this cycle lands on y
);

    logic         step_en;
    logic [W-1:0] i_inc;

    assign i_inc   = i + W'(1);
    assign lt_y    = (i < y);
    assign at_y    = (i == y);
    assign step_en = inc && lt_y;
    assign hit_y   = step_en && (i_inc == y);

    // Index register: clear wins, otherwise bounded increment.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i <= '0;
        end else if (clr) begin
            i <= '0;
        end else if (step_en) begin
            i <= i_inc;
        end
    end

endmodule : step_counter

// File: rtl/step_bound_ctrl.sv
// Bounded step controller. Holds an upper bound x and target bound y
// (loaded through a valid/ready handshake that rejects y > x), and runs
// an index from 0 up to y, advancing on accepted step requests.
module step_bound_ctrl
    import step_bound_ctrl_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int X_RST = X_RST_DEF,
    parameter int Y_RST = Y_RST_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_x,
    input  logic [W-1:0] cfg_y,
    input  logic         start,
    input  logic         abort,
    input  logic         step_req,
    output logic         sel_out,
    output logic [W-1:0] i_out,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic         busy,
    output logic         done,
    output logic         cfg_err
);

    state_t       state_q;
    state_t       state_d;

    logic [W-1:0] x_q;
    logic [W-1:0] y_q;

    logic         hs;          // handshake offered and accepted by state
    logic         cfg_ok;      // offered pair satisfies y <= x
    logic         load_cfg;
    logic         cfg_err_d;
    logic         cnt_clr;
    logic         cnt_inc;
    logic         sel_d;

    logic         cnt_at_y;
    logic         cnt_lt_y;
    logic         cnt_hit_y;

    // Ready is the only combinational output: it depends on state alone.
    assign cfg_ready = (state_q != ST_RUN);
    assign hs        = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_y <= cfg_x);

    step_counter #(
        .W (W)
    ) u_step_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .y     (y_q),
        .i     (i_out),
        .at_y  (cnt_at_y),
        .lt_y  (cnt_lt_y),
        .hit_y (cnt_hit_y)
    );

    // Next-state and control decode for the IDLE/RUN/DONE controller.
    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        load_cfg  = 1'b0;
        cfg_err_d = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        sel_d     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (hs && cfg_ok) begin
                    // Accepted handshake beats a same-cycle start.
                    load_cfg = 1'b1;
                    cnt_clr  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    // A rejected pair only raises the error pulse; a start
                    // offered alongside it still takes effect.
                    cfg_err_d = hs;
                    if (start) begin
                        cnt_clr = 1'b1;
                        state_d = (y_q != '0) ? ST_RUN : ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // Abort holds the index and suppresses any step.
                    state_d = ST_IDLE;
                end else if (step_req) begin
                    cnt_inc = 1'b1;
                    sel_d   = cnt_lt_y;
                    if (cnt_hit_y) begin
                        state_d = ST_DONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bound registers change only on an accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= W'(X_RST);
            y_q <= W'(Y_RST);
        end else if (load_cfg) begin
            x_q <= cfg_x;
            y_q <= cfg_y;
        end
    end

    // Registered status outputs, derived from the next state and decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_out <= 1'b0;
            cfg_err <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            sel_out <= sel_d;
            cfg_err <= cfg_err_d;
            busy    <= (state_d == ST_RUN);
            done    <= (state_d == ST_DONE);
        end
    end

    assign x_out = x_q;
    assign y_out = y_q;

endmodule : step_bound_ctrl

// File: tb/tb_step_bound_ctrl.sv
// Self-checking bench for step_bound_ctrl: a table of directed single-cycle
// vectors, plus hand-written sequences for the long run and async reset.
module tb_step_bound_ctrl;
    import step_bound_ctrl_pkg::*;

    localparam int W = W_DEF;

    logic         clk;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_x;
    logic [W-1:0] cfg_y;
    logic         start;
    logic         abort;
    logic         step_req;
    logic         sel_out;
    logic [W-1:0] i_out;
    logic [W-1:0] x_out;
    logic [W-1:0] y_out;
    logic         busy;
    logic         done;
    logic         cfg_err;

    int checks   = 0;
    int failures = 0;
    bit inv_en   = 0;

    step_bound_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_x     (cfg_x),
        .cfg_y     (cfg_y),
        .start     (start),
        .abort     (abort),
        .step_req  (step_req),
        .sel_out   (sel_out),
        .i_out     (i_out),
        .x_out     (x_out),
        .y_out     (y_out),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [W-1:0] cx;
        logic [W-1:0] cy;
        logic         st;
        logic         ab;
        logic         sr;
        logic         e_ready;
        logic         e_sel;
        logic [W-1:0] e_i;
        logic [W-1:0] e_x;
        logic [W-1:0] e_y;
        logic         e_busy;
        logic         e_done;
        logic         e_err;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input int cx, input int cy,
                                input logic st, input logic ab, input logic sr,
                                input logic rdy, input logic sel, input int i,
                                input int x, input int y, input logic bz,
                                input logic dn, input logic er);
        vec_t r;
        r.v = v; r.cx = W'(cx); r.cy = W'(cy); r.st = st; r.ab = ab; r.sr = sr;
        r.e_ready = rdy; r.e_sel = sel; r.e_i = W'(i); r.e_x = W'(x);
        r.e_y = W'(y); r.e_busy = bz; r.e_done = dn; r.e_err = er;
        return r;
    endfunction

    task automatic idle_inputs();
        cfg_valid = 1'b0;
        cfg_x     = '0;
        cfg_y     = '0;
        start     = 1'b0;
        abort     = 1'b0;
        step_req  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_i"},     i_out,     0);
        check({tag, "_x"},     x_out,     500);
        check({tag, "_y"},     y_out,     450);
        check({tag, "_sel"},   sel_out,   0);
        check({tag, "_err"},   cfg_err,   0);
        check({tag, "_busy"},  busy,      0);
        check({tag, "_done"},  done,      0);
        check({tag, "_ready"}, cfg_ready, 1);
    endtask

    // Invariant i <= y <= x, sampled away from the active edge.
    always @(negedge clk) begin
        if (inv_en && !rst) begin
            check("invariant", {31'd0, (i_out <= y_out) && (y_out <= x_out)}, 1);
        end
    end

    initial begin
        int sel_cnt;
        bit got_done;

        rst = 1'b1;
        idle_inputs();

        //                  v  cx   cy  st ab sr   rdy sel i  x    y    bz dn er
        vecs[0]  = mk(1, 10,  20,  0, 0, 0,   1, 0, 0, 500, 450, 0, 0, 1); // y>x rejected
        vecs[1]  = mk(0, 0,   0,   0, 0, 0,   1, 0, 0, 500, 450, 0, 0, 0); // err one cycle
        vecs[2]  = mk(0, 0,   0,   0, 1, 0,   1, 0, 0, 500, 450, 0, 0, 0); // abort in IDLE
        vecs[3]  = mk(1, 5,   0,   0, 0, 0,   1, 0, 0, 5,   0,   0, 0, 0); // load 5/0
        vecs[4]  = mk(0, 0,   0,   1, 0, 1,   1, 0, 0, 5,   0,   0, 1, 0); // y==0 -> DONE
        vecs[5]  = mk(0, 0,   0,   0, 0, 1,   1, 0, 0, 5,   0,   0, 1, 0); // DONE holds
        vecs[6]  = mk(1, 8,   3,   1, 0, 0,   1, 0, 0, 8,   3,   0, 0, 0); // hs beats start
        vecs[7]  = mk(0, 0,   0,   1, 0, 0,   0, 0, 0, 8,   3,   1, 0, 0); // RUN
        vecs[8]  = mk(0, 0,   0,   0, 0, 1,   0, 1, 1, 8,   3,   1, 0, 0);
        vecs[9]  = mk(0, 0,   0,   0, 0, 0,   0, 0, 1, 8,   3,   1, 0, 0);
        vecs[10] = mk(0, 0,   0,   0, 0, 1,   0, 1, 2, 8,   3,   1, 0, 0);
        vecs[11] = mk(0, 0,   0,   0, 0, 1,   1, 1, 3, 8,   3,   0, 1, 0); // hits y
        vecs[12] = mk(0, 0,   0,   0, 0, 1,   1, 0, 3, 8,   3,   0, 1, 0); // no step past y
        vecs[13] = mk(1, 7,   9,   0, 0, 0,   1, 0, 3, 8,   3,   0, 1, 1); // reject in DONE
        vecs[14] = mk(0, 0,   0,   1, 0, 0,   0, 0, 0, 8,   3,   1, 0, 0); // restart
        vecs[15] = mk(0, 0,   0,   0, 0, 1,   0, 1, 1, 8,   3,   1, 0, 0);
        vecs[16] = mk(0, 0,   0,   0, 0, 1,   0, 1, 2, 8,   3,   1, 0, 0);
        vecs[17] = mk(0, 0,   0,   0, 1, 1,   1, 0, 2, 8,   3,   0, 0, 0); // abort beats step
        vecs[18] = mk(0, 0,   0,   1, 0, 0,   0, 0, 0, 8,   3,   1, 0, 0);
        vecs[19] = mk(1, 100, 50,  0, 0, 0,   0, 0, 0, 8,   3,   1, 0, 0); // cfg ignored in RUN
        vecs[20] = mk(0, 0,   0,   0, 0, 1,   0, 1, 1, 8,   3,   1, 0, 0);

        // Reset state, checked while reset is still applied.
        #2;
        check_reset_values("rst_hold");
        @(negedge clk);
        rst    = 1'b0;
        inv_en = 1'b1;

        for (int n = 0; n < 21; n++) begin
            @(negedge clk);
            cfg_valid = vecs[n].v;
            cfg_x     = vecs[n].cx;
            cfg_y     = vecs[n].cy;
            start     = vecs[n].st;
            abort     = vecs[n].ab;
            step_req  = vecs[n].sr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ready", n), cfg_ready, vecs[n].e_ready);
            check($sformatf("v%0d_sel", n),   sel_out,   vecs[n].e_sel);
            check($sformatf("v%0d_i", n),     i_out,     vecs[n].e_i);
            check($sformatf("v%0d_x", n),     x_out,     vecs[n].e_x);
            check($sformatf("v%0d_y", n),     y_out,     vecs[n].e_y);
            check($sformatf("v%0d_busy", n),  busy,      vecs[n].e_busy);
            check($sformatf("v%0d_done", n),  done,      vecs[n].e_done);
            check($sformatf("v%0d_err", n),   cfg_err,   vecs[n].e_err);
        end

        // Full default run: 450 accepted steps from reset values.
        do_reset();
        start    = 1'b1;
        step_req = 1'b1;
        @(posedge clk);
        #1;
        check("long_busy", busy, 1);
        @(negedge clk);
        start    = 1'b0;
        sel_cnt  = 0;
        got_done = 0;
        for (int c = 0; c < 600 && !got_done; c++) begin
            @(posedge clk);
            #1;
            if (sel_out) sel_cnt++;
            if (done) got_done = 1;
        end
        check("long_done_seen", {31'd0, got_done}, 1);
        check("long_sel_cycles", sel_cnt, 450);
        check("long_i", i_out, 450);
        check("long_busy_end", busy, 0);
        @(posedge clk);
        #1;
        check("long_sel_after", sel_out, 0);
        check("long_i_hold", i_out, 450);
        check("long_done_hold", done, 1);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        idle_inputs();
        cfg_valid = 1'b1;
        cfg_x     = W'(40);
        cfg_y     = W'(30);
        @(negedge clk);
        idle_inputs();
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        step_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_i_before", i_out, 2);
        check("mid_x_before", x_out, 40);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        rst      = 1'b0;
        step_req = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_idle_i", i_out, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_run_busy", busy, 1);
        check("post_rst_run_i", i_out, 0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_step_i", i_out, 1);
        check("post_rst_step_sel", sel_out, 1);

        @(negedge clk);
        idle_inputs();
        inv_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_step_bound_ctrl
